// File: rtl/ex_pipe_ctrl.sv
// EX-stage hazard, forwarding and redirect controller for the 16-bit pipeline.
// Owns the architectural {N,Z,V} flags and the stall/flush performance counters.
module ex_pipe_ctrl #(
    parameter logic [3:0]  OP_B   = 4'b1100,
    parameter logic [3:0]  OP_JAL = 4'b1101,
    parameter logic [3:0]  OP_JR  = 4'b1110,
    parameter logic [3:0]  OP_HLT = 4'b1111,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [3:0]       ex_op,
    input  logic [2:0]       ex_cond,
    input  logic [3:0]       ex_rs,
    input  logic [3:0]       ex_rt,
    input  logic [3:0]       ex_rd,
    input  logic             ex_reg_we,
    input  logic             ex_mem_rd,
    input  logic [3:0]       mem_rd,
    input  logic [3:0]       wb_rd,
    input  logic             mem_reg_we,
    input  logic             wb_reg_we,
    input  logic [2:0]       ex_flags_in,
    input  logic             ex_flags_we,
    input  logic             mem_busy,
    output logic [1:0]       pc_sel,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [2:0]       flags_q,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] MEMWAIT = 2'd1;
    localparam logic [1:0] HALT    = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] stateQ;
    logic [1:0] stateD;
    logic       live;
    logic       isHlt;
    logic       condTrue;
    logic       redirect;
    logic       loadUse;

    // MEMWAIT with mem_busy already low behaves as RUN so the released
    // instruction acts in the first non-busy cycle.
    assign live  = (stateQ != HALT) && !mem_busy;
    assign isHlt = (ex_op == OP_HLT);

    always_comb begin
        condTrue = 1'b0;
        case (ex_cond)
            3'b000: condTrue = !flags_q[1];
            3'b001: condTrue = flags_q[1];
            3'b010: condTrue = !flags_q[1] && !flags_q[2];
            3'b011: condTrue = flags_q[2];
            3'b100: condTrue = flags_q[1] || !flags_q[2];
            3'b101: condTrue = flags_q[1] || flags_q[2];
            3'b110: condTrue = flags_q[0];
            3'b111: condTrue = 1'b1;
            default: condTrue = 1'b0;
        endcase
    end

    assign redirect = live && !isHlt &&
                      ((ex_op == OP_JAL) || (ex_op == OP_JR) || ((ex_op == OP_B) && condTrue));

    // A load that writes no register cannot create a hazard.
    assign loadUse = ex_mem_rd && ex_reg_we && (ex_rd != 4'd0) &&
                     ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            RUN, MEMWAIT: begin
                if (mem_busy)   stateD = MEMWAIT;
                else if (isHlt) stateD = HALT;
                else            stateD = RUN;
            end
            HALT:    stateD = HALT;
            default: stateD = RUN;
        endcase
    end

    always_comb begin
        pc_sel   = 2'b00;
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        freeze   = 1'b0;
        fwd_a    = 2'b00;
        fwd_b    = 2'b00;
        halted   = 1'b0;
        if (rst_n) begin
            if (stateQ == HALT) begin
                pc_sel   = 2'b10;
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
                halted   = 1'b1;
            end else if (mem_busy) begin
                pc_sel   = 2'b10;
                stall_if = 1'b1;
                stall_id = 1'b1;
                freeze   = 1'b1;
            end else if (isHlt) begin
                pc_sel   = 2'b10;
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (redirect) begin
                pc_sel   = 2'b01;
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (loadUse) begin
                pc_sel   = 2'b10;
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end

            if (mem_reg_we && (mem_rd != 4'd0) && (mem_rd == ex_rs))     fwd_a = 2'b10;
            else if (wb_reg_we && (wb_rd != 4'd0) && (wb_rd == ex_rs))   fwd_a = 2'b01;
            if (mem_reg_we && (mem_rd != 4'd0) && (mem_rd == ex_rt))     fwd_b = 2'b10;
            else if (wb_reg_we && (wb_rd != 4'd0) && (wb_rd == ex_rt))   fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= RUN;
            flags_q   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stateQ <= stateD;
            if (ex_flags_we && live && !isHlt)
                flags_q <= ex_flags_in;
            if (stall_if && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Self-checking bench for ex_pipe_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the pipeline control rules.
module tb_ex_pipe_ctrl;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_JAL = 4'b1101;
    localparam logic [3:0] OP_JR  = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs, id_rt, ex_op, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs, id_use_rt, ex_reg_we, ex_mem_rd, mem_reg_we, wb_reg_we;
    logic [2:0]  ex_cond, ex_flags_in;
    logic        ex_flags_we, mem_busy;
    logic [1:0]  pc_sel, fwd_a, fwd_b;
    logic        stall_if, stall_id, flush_id, flush_ex, freeze, halted;
    logic [2:0]  flags_q;
    logic [15:0] stall_cnt, flush_cnt;

    int unsigned passCnt = 0;
    int unsigned totalCnt = 0;

    // Behavioural model state and expected outputs
    logic [2:0]  mFlags;
    logic        mHalted;
    int unsigned mStall, mFlush;
    logic [1:0]  ePc, eFwdA, eFwdB;
    logic        eStall, eFlushId, eFlushEx, eFreeze, eRedirect;

    always #5 clk = ~clk;

    ex_pipe_ctrl #(.OP_B(OP_B), .OP_JAL(OP_JAL), .OP_JR(OP_JR), .OP_HLT(OP_HLT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_op(ex_op), .ex_cond(ex_cond), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_we(mem_reg_we), .wb_reg_we(wb_reg_we),
        .ex_flags_in(ex_flags_in), .ex_flags_we(ex_flags_we), .mem_busy(mem_busy),
        .pc_sel(pc_sel), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .flush_ex(flush_ex), .freeze(freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .flags_q(flags_q), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic branchTaken(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] srcSel(input logic [3:0] src);
        if (mem_reg_we && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (wb_reg_we && wb_rd != 0 && wb_rd == src)   return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_op = 4'b0001; ex_cond = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_reg_we = 0; ex_mem_rd = 0; mem_rd = 0; wb_rd = 0; mem_reg_we = 0; wb_reg_we = 0;
        ex_flags_in = 0; ex_flags_we = 0; mem_busy = 0;
    endtask

    task automatic checkComb();
        logic lu, jump;
        ePc = 0; eStall = 0; eFlushId = 0; eFlushEx = 0; eFreeze = 0; eRedirect = 0;
        eFwdA = 0; eFwdB = 0;
        if (rst_n) begin
            lu = ex_mem_rd && ex_rd != 0 &&
                 ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
            jump = (ex_op == OP_JAL) || (ex_op == OP_JR) ||
                   (ex_op == OP_B && branchTaken(ex_cond, mFlags));
            if (mHalted) begin
                ePc = 2; eStall = 1; eFlushEx = 1;
            end else if (mem_busy) begin
                ePc = 2; eStall = 1; eFreeze = 1;
            end else if (ex_op == OP_HLT) begin
                ePc = 2; eStall = 1;
            end else if (jump) begin
                ePc = 1; eFlushId = 1; eFlushEx = 1; eRedirect = 1;
            end else if (lu) begin
                ePc = 2; eStall = 1; eFlushEx = 1;
            end
            eFwdA = srcSel(ex_rs);
            eFwdB = srcSel(ex_rt);
        end
        chk("pc_sel", pc_sel, ePc);
        chk("stall_if", stall_if, eStall);
        chk("stall_id", stall_id, eStall);
        chk("flush_id", flush_id, eFlushId);
        chk("flush_ex", flush_ex, eFlushEx);
        chk("freeze", freeze, eFreeze);
        chk("fwd_a", fwd_a, eFwdA);
        chk("fwd_b", fwd_b, eFwdB);
    endtask

    task automatic checkRegs();
        chk("flags_q", flags_q, mFlags);
        chk("halted", halted, mHalted);
        chk("stall_cnt", stall_cnt, mStall);
        chk("flush_cnt", flush_cnt, mFlush);
    endtask

    // Starts one time unit after a rising edge, ends one time unit after the next.
    task automatic cycle();
        #2;
        checkComb();
        @(posedge clk);
        if (eStall && mStall < 65535) mStall++;
        if (eRedirect && mFlush < 65535) mFlush++;
        if (!mHalted && !mem_busy && ex_op != OP_HLT && ex_flags_we) mFlags = ex_flags_in;
        if (!mHalted && !mem_busy && ex_op == OP_HLT) mHalted = 1;
        #1;
        checkRegs();
    endtask

    task automatic doRst();
        rst_n = 0;
        mFlags = 0; mHalted = 0; mStall = 0; mFlush = 0;
        #2;
        checkComb();
        checkRegs();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic randInputs();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 2)       ex_op = OP_B;
        else if (r == 2) ex_op = OP_JAL;
        else if (r == 3) ex_op = OP_JR;
        else             ex_op = 4'($urandom_range(0, 11));
        ex_cond = 3'($urandom_range(0, 7));
        id_rs = 4'($urandom_range(0, 7)); id_rt = 4'($urandom_range(0, 7));
        id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
        ex_rs = 4'($urandom_range(0, 7)); ex_rt = 4'($urandom_range(0, 7));
        ex_rd = 4'($urandom_range(0, 7));
        ex_mem_rd = 1'($urandom);
        ex_reg_we = ex_mem_rd | 1'($urandom);
        mem_rd = 4'($urandom_range(0, 7)); wb_rd = 4'($urandom_range(0, 7));
        mem_reg_we = 1'($urandom); wb_reg_we = 1'($urandom);
        ex_flags_in = 3'($urandom); ex_flags_we = 1'($urandom);
        mem_busy = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;

        // Reset with hazard-provoking inputs: everything must stay inactive
        mem_reg_we = 1; mem_rd = 3; ex_rs = 3; ex_op = OP_JAL; mem_busy = 1;
        doRst();

        // Forwarding: MEM beats WB; R0 never forwarded
        idle();
        mem_reg_we = 1; mem_rd = 3; wb_reg_we = 1; wb_rd = 3; ex_rs = 3; ex_rt = 3;
        cycle();
        chk("fwd_a_mem", fwd_a, 2'b10);
        chk("fwd_b_mem", fwd_b, 2'b10);
        mem_rd = 0;
        cycle();
        chk("fwd_a_wb", fwd_a, 2'b01);
        chk("fwd_b_wb", fwd_b, 2'b01);
        wb_rd = 0; ex_rs = 0; ex_rt = 0;
        cycle();
        chk("fwd_r0", fwd_a, 2'b00);

        // Load-use: one stall cycle then clear
        doRst();
        idle();
        ex_mem_rd = 1; ex_reg_we = 1; ex_rd = 5; id_use_rs = 1; id_rs = 5;
        cycle();
        idle();
        cycle();
        chk("lu_clear", stall_if, 1'b0);
        chk("lu_cnt", stall_cnt, 16'd1);

        // Flag-setting SUB then branch on Z
        idle();
        ex_flags_we = 1; ex_flags_in = 3'b010;
        cycle();
        idle();
        ex_op = OP_B; ex_cond = 3'b001;
        cycle();
        chk("br_pc", pc_sel, 2'b01);
        chk("br_flush_cnt", flush_cnt, 16'd1);
        ex_cond = 3'b000;
        cycle();
        chk("br_not_taken", pc_sel, 2'b00);

        // Memory freeze with a taken branch waiting in EX
        ex_cond = 3'b001; mem_busy = 1; ex_flags_we = 1; ex_flags_in = 3'b000;
        repeat (3) begin
            cycle();
            chk("frz_pc", pc_sel, 2'b10);
            chk("frz_flags", flags_q, 3'b010);
        end
        mem_busy = 0; ex_flags_we = 0;
        cycle();
        chk("frz_release_redirect", flush_cnt, 16'd2);

        // Random traffic with occasional mid-stream resets
        for (int i = 0; i < 800; i++) begin
            randInputs();
            if ($urandom_range(0, 99) == 0) doRst();
            else cycle();
        end

        // Counter saturation under a persistent load-use
        doRst();
        idle();
        ex_mem_rd = 1; ex_reg_we = 1; ex_rd = 5; id_use_rt = 1; id_rt = 5;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            if (mStall < 65535) mStall++;
        end
        #1;
        cycle();
        chk("stall_sat", stall_cnt, 16'hFFFF);

        // Halt is terminal until reset
        doRst();
        idle();
        ex_op = OP_HLT;
        cycle();
        chk("halt_set", halted, 1'b1);
        for (int i = 0; i < 5; i++) begin
            randInputs();
            cycle();
            chk("halt_pc", pc_sel, 2'b10);
        end
        doRst();
        chk("halt_cleared", halted, 1'b0);
        chk("flags_cleared", flags_q, 3'b000);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
